// File: rtl/ram256_arbiter.sv
//==============================================================================
// ram256_arbiter: two-requester valid/ready front end sharing one 256-bit RAM
// port, with a programmable access latency and registered responses. Rev 1.0
//==============================================================================
`default_nettype none

module ram256_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [255:0]      req0_wdata,
  input  logic [31:0]       req0_wmask,
  input  logic              req0_wen,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [255:0]      req1_wdata,
  input  logic [31:0]       req1_wmask,
  input  logic              req1_wen,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [255:0]      resp0_rdata,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [255:0]      resp1_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [255:0]      ram_wdata,
  output logic [31:0]       ram_wmask,
  output logic              ram_wen,
  input  logic [255:0]      ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LOAD = 8'(LATENCY - 1);

  state_t              r_state;
  logic                r_prio;
  logic                r_owner;
  logic [7:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [255:0]        r_wdata;
  logic [31:0]         r_wmask;
  logic                r_wen;
  logic                r_resp0_valid;
  logic                r_resp1_valid;
  logic [255:0]        r_rdata0;
  logic [255:0]        r_rdata1;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_fire;
  logic w_ram_en;
  logic w_resp_fire;

  // Grants are gated by reset so every ready reads 0 while reset is held.
  assign w_idle      = (r_state == S_IDLE) && !reset;
  assign w_grant0    = req0_valid && (!req1_valid || !r_prio);
  assign w_grant1    = req1_valid && (!req0_valid ||  r_prio);
  assign req0_ready  = w_idle && w_grant0;
  assign req1_ready  = w_idle && w_grant1;
  assign w_fire      = req0_ready || req1_ready;
  assign w_resp_fire = (r_resp0_valid && resp0_ready) || (r_resp1_valid && resp1_ready);

  assign w_ram_en  = (r_state == S_ACCESS) && (r_cnt == 8'd0);
  assign ram_en    = w_ram_en;
  assign ram_addr  = w_ram_en ? r_addr  : '0;
  assign ram_wdata = w_ram_en ? r_wdata : '0;
  assign ram_wmask = w_ram_en ? r_wmask : '0;
  assign ram_wen   = w_ram_en && r_wen;

  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp0_rdata = r_rdata0;
  assign resp1_rdata = r_rdata1;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_cnt         <= 8'd0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_wen         <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_owner  <= req1_ready;
            r_addr   <= req1_ready ? req1_addr  : req0_addr;
            r_wdata  <= req1_ready ? req1_wdata : req0_wdata;
            r_wmask  <= req1_ready ? req1_wmask : req0_wmask;
            r_wen    <= req1_ready ? req1_wen   : req0_wen;
            r_cnt    <= C_CNT_LOAD;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            // Only the owner's response register ever carries data.
            r_resp0_valid <= !r_owner;
            r_resp1_valid <=  r_owner;
            r_rdata0      <= (!r_owner && !r_wen) ? ram_rdata : '0;
            r_rdata1      <= ( r_owner && !r_wen) ? ram_rdata : '0;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (w_resp_fire) begin
            r_prio        <= ~r_owner;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
